mc_control_fsm: RTL and testbench
=================================

# mc_control_fsm

Multicycle main control unit for the MIPS core. It sequences the datapath through fetch, decode, execute, memory and write-back. It drives the PC update controls (write enable and next-PC source) and the register-file, ALU and memory control lines. It handshakes with a shared instruction/data memory port and sits between the instruction register opcode field and the PC/ALU/register-file datapath.

## Interface
Parameters:
- none (all encodings come from the shared package)

Ports:
- CLK  in  1  clock; all state changes on rising edge
- RST  in  1  reset, asynchronous, active-high
- Op  in  6  opcode field from the instruction register
- ALUZero  in  1  ALU zero flag from the datapath
- MemReady  in  1  memory completion strobe for the current MemRead/MemWrite
- PCWrite  out  1  load PC this cycle
- PCSrc  out  2  next-PC select: 00 PC+4, 01 branch target, 10 jump target
- IRWrite  out  1  load instruction register
- MemRead  out  1  memory read request; held until MemReady
- MemWrite  out  1  memory write request; held until MemReady
- IorD  out  1  memory address: 0 PC, 1 ALUOut
- RegWrite, RegDst, MemtoReg  out  1 each  register-file write controls
- ALUSrcA  out  1  0 PC, 1 rs
- ALUSrcB  out  2  00 rt, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
- ALUOp  out  2  00 add, 01 sub, 10 funct, 11 immediate-logic (ori/lui)
- Illegal  out  1  sticky illegal-opcode flag
- State  out  3  current state, for debug

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, ILLEGAL.
- FETCH: MemRead=1, IorD=0. When MemReady=1: IRWrite=1, PCWrite=1, PCSrc=00, then go to DECODE. Otherwise stay in FETCH.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (precompute branch target). Next state by Op:
  - 000000 R-type, 100011 lw, 101011 sw, 000100 beq, 000010 j, 001000 addi, 001101 ori, 001111 lui → EXEC
  - any other opcode → ILLEGAL
- EXEC:
  - R-type: ALUSrcA=1, ALUSrcB=00, ALUOp=10 → WB.
  - lw/sw/addi: ALUSrcB=10, ALUOp=00. lw/sw → MEM; addi → WB.
  - ori/lui: ALUSrcB=10, ALUOp=11 → WB.
  - beq: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=01, PCWrite=ALUZero → FETCH.
  - j: PCSrc=10, PCWrite=1 → FETCH.
- MEM: IorD=1.
  - lw: MemRead=1; on MemReady → WB.
  - sw: MemWrite=1; on MemReady → FETCH.
  - Without MemReady, stay in MEM.
- WB:
  - RegWrite=1.
  - R-type: RegDst=1, MemtoReg=0.
  - lw: RegDst=0, MemtoReg=1.
  - addi/ori/lui: RegDst=0, MemtoReg=0.
  - → FETCH.
- ILLEGAL: Illegal=1, all controls 0, terminal until RST.
- Outputs are Moore-decoded from the state. In EXEC, PCWrite also depends on ALUZero. In FETCH and MEM, IRWrite, PCWrite and the transition depend on MemReady.
- Every control output not listed for a state is 0.
- MemReady is ignored outside FETCH and MEM.

## Timing
- Reset: while RST=1, State=FETCH and every output is 0, including MemRead and Illegal. The first fetch request is on the first rising edge after RST falls.
- Latencies with zero-wait memory (MemReady high in the cycle of the request):
  - beq, j: 3 cycles
  - R-type, sw, addi, ori, lui: 4 cycles
  - lw: 5 cycles
- Each cycle that MemReady stays low in FETCH or MEM adds one cycle.
- MemRead/MemWrite must stay stable and asserted until the MemReady cycle. They deassert on the following edge.
- RST asserted mid-instruction, including while waiting in MEM: MemRead/MemWrite drop immediately (asynchronously), no PCWrite or RegWrite is issued, and State returns to FETCH.
- beq with ALUZero=0: PCWrite=0, PC keeps the PC+4 loaded in FETCH.

## Configuration
- MCCTRL_BNE_EN defined:
  - Op 000101 (bne) is legal.
  - EXEC drives ALUOp=01, PCSrc=01, PCWrite=~ALUZero → FETCH.
- Undefined: 000101 decodes to ILLEGAL.

## Structure
- Package mc_ctrl_pkg holds:
  - state encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, ILLEGAL=5
  - opcode constants
  - PCSrc, ALUSrcB and ALUOp codes
  - instruction-class enum
- One sub-module, mc_op_decode: purely combinational Op → instruction class plus legal bit. The bne case sits under MCCTRL_BNE_EN.
- The FSM register and output decode live in mc_control_fsm.

## Test plan
- **Reset then R-type (Op=000000), MemReady tied 1:**
  - States FETCH, DECODE, EXEC, WB, FETCH.
  - PCWrite=1 only in cycle 1.
  - RegWrite=1, RegDst=1 in cycle 4.
- **lw (100011), MemReady low for 2 cycles in MEM:**
  - MemRead and IorD=1 held for 3 cycles.
  - WB has MemtoReg=1; 7 cycles total.
- **beq (000100):**
  - ALUZero=1 → PCWrite=1 with PCSrc=01 in EXEC.
  - Repeat with ALUZero=0 → PCWrite=0; back to FETCH after 3 cycles.
- **j (000010):** EXEC drives PCWrite=1, PCSrc=10; next state FETCH.
- **Illegal Op=111111:**
  - ILLEGAL after DECODE; Illegal=1; no PCWrite even when MemReady pulses.
  - RST clears to FETCH with Illegal=0.
  - With MCCTRL_BNE_EN, Op=000101 and ALUZero=0 → PCWrite=1.
- **RST during a sw wait in MEM:** MemWrite drops in the same cycle, and FETCH restarts after RST falls.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// rtl/mc_ctrl_pkg.sv - shared encodings for the multicycle MIPS control unit
package mc_ctrl_pkg;

   typedef enum logic [2:0] {
      S_FETCH   = 3'd0,
      S_DECODE  = 3'd1,
      S_EXEC    = 3'd2,
      S_MEM     = 3'd3,
      S_WB      = 3'd4,
      S_ILLEGAL = 3'd5
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LUI   = 6'b001111;

   localparam logic [1:0] PCSRC_PC4 = 2'b00;
   localparam logic [1:0] PCSRC_BR  = 2'b01;
   localparam logic [1:0] PCSRC_JMP = 2'b10;

   localparam logic [1:0] ALUB_RT    = 2'b00;
   localparam logic [1:0] ALUB_FOUR  = 2'b01;
   localparam logic [1:0] ALUB_IMM   = 2'b10;
   localparam logic [1:0] ALUB_IMMSH = 2'b11;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;
   localparam logic [1:0] ALUOP_LOGI  = 2'b11;

   typedef enum logic [3:0] {
      C_NONE  = 4'd0,
      C_RTYPE = 4'd1,
      C_LW    = 4'd2,
      C_SW    = 4'd3,
      C_BEQ   = 4'd4,
      C_BNE   = 4'd5,
      C_J     = 4'd6,
      C_ADDI  = 4'd7,
      C_ORI   = 4'd8,
      C_LUI   = 4'd9
   } iclass_t;

endpackage

// File: rtl/mc_control_fsm_op_decode.sv
// rtl/mc_control_fsm_op_decode.sv - opcode to instruction class; bne legal only with MCCTRL_BNE_EN
module mc_op_decode
   import mc_ctrl_pkg::*;
(
   input  logic [5:0] i_op,
   output iclass_t    o_cls,
   output logic       o_legal
);

   always_comb begin
      o_cls   = C_NONE;
      o_legal = 1'b1;
      case (i_op)
         OP_RTYPE: o_cls = C_RTYPE;
         OP_LW:    o_cls = C_LW;
         OP_SW:    o_cls = C_SW;
         OP_BEQ:   o_cls = C_BEQ;
`ifdef MCCTRL_BNE_EN
         OP_BNE:   o_cls = C_BNE;
`endif
         OP_J:     o_cls = C_J;
         OP_ADDI:  o_cls = C_ADDI;
         OP_ORI:   o_cls = C_ORI;
         OP_LUI:   o_cls = C_LUI;
         default:  o_legal = 1'b0;
      endcase
   end

endmodule

// File: rtl/mc_control_fsm.sv
// rtl/mc_control_fsm.sv - multicycle MIPS main control FSM; bne support under MCCTRL_BNE_EN
module mc_control_fsm
   import mc_ctrl_pkg::*;
(
   input  logic       CLK,
   input  logic       RST,
   input  logic [5:0] Op,
   input  logic       ALUZero,
   input  logic       MemReady,
   output logic       PCWrite,
   output logic [1:0] PCSrc,
   output logic       IRWrite,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       IorD,
   output logic       RegWrite,
   output logic       RegDst,
   output logic       MemtoReg,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ALUOp,
   output logic       Illegal,
   output logic [2:0] State
);

   state_t  r_state;
   state_t  w_next;
   iclass_t r_cls;
   iclass_t w_cls;
   logic    w_legal;

   mc_op_decode u_dec (
      .i_op    (Op),
      .o_cls   (w_cls),
      .o_legal (w_legal)
   );

   // Class is latched at DECODE so later states do not depend on Op staying put.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state <= S_FETCH;
         r_cls   <= C_NONE;
      end else begin
         r_state <= w_next;
         if (r_state == S_DECODE)
            r_cls <= w_cls;
      end
   end

   assign State = r_state;

   // Gating by RST makes the memory requests drop immediately on an async reset.
   always_comb begin
      w_next   = r_state;
      PCWrite  = 1'b0;
      PCSrc    = PCSRC_PC4;
      IRWrite  = 1'b0;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      IorD     = 1'b0;
      RegWrite = 1'b0;
      RegDst   = 1'b0;
      MemtoReg = 1'b0;
      ALUSrcA  = 1'b0;
      ALUSrcB  = ALUB_RT;
      ALUOp    = ALUOP_ADD;
      Illegal  = 1'b0;
      if (!RST) begin
         case (r_state)
            S_FETCH: begin
               MemRead = 1'b1;
               if (MemReady) begin
                  IRWrite = 1'b1;
                  PCWrite = 1'b1;
                  PCSrc   = PCSRC_PC4;
                  w_next  = S_DECODE;
               end
            end
            S_DECODE: begin
               ALUSrcA = 1'b0;
               ALUSrcB = ALUB_IMMSH;
               ALUOp   = ALUOP_ADD;
               w_next  = w_legal ? S_EXEC : S_ILLEGAL;
            end
            S_EXEC: begin
               w_next = S_FETCH;
               case (r_cls)
                  C_RTYPE: begin
                     ALUSrcA = 1'b1;
                     ALUSrcB = ALUB_RT;
                     ALUOp   = ALUOP_FUNCT;
                     w_next  = S_WB;
                  end
                  C_LW, C_SW, C_ADDI: begin
                     ALUSrcB = ALUB_IMM;
                     ALUOp   = ALUOP_ADD;
                     w_next  = (r_cls == C_ADDI) ? S_WB : S_MEM;
                  end
                  C_ORI, C_LUI: begin
                     ALUSrcB = ALUB_IMM;
                     ALUOp   = ALUOP_LOGI;
                     w_next  = S_WB;
                  end
                  C_BEQ: begin
                     ALUSrcA = 1'b1;
                     ALUSrcB = ALUB_RT;
                     ALUOp   = ALUOP_SUB;
                     PCSrc   = PCSRC_BR;
                     PCWrite = ALUZero;
                  end
`ifdef MCCTRL_BNE_EN
                  C_BNE: begin
                     ALUOp   = ALUOP_SUB;
                     PCSrc   = PCSRC_BR;
                     PCWrite = ~ALUZero;
                  end
`endif
                  C_J: begin
                     PCSrc   = PCSRC_JMP;
                     PCWrite = 1'b1;
                  end
                  default: w_next = S_FETCH;
               endcase
            end
            S_MEM: begin
               IorD = 1'b1;
               case (r_cls)
                  C_LW: begin
                     MemRead = 1'b1;
                     if (MemReady) w_next = S_WB;
                  end
                  C_SW: begin
                     MemWrite = 1'b1;
                     if (MemReady) w_next = S_FETCH;
                  end
                  default: w_next = S_FETCH;
               endcase
            end
            S_WB: begin
               RegWrite = 1'b1;
               RegDst   = (r_cls == C_RTYPE);
               MemtoReg = (r_cls == C_LW);
               w_next   = S_FETCH;
            end
            S_ILLEGAL: begin
               Illegal = 1'b1;
            end
            default: w_next = S_FETCH;
         endcase
      end
   end

endmodule

// File: tb/tb_mc_control_fsm.sv
// tb/tb_mc_control_fsm.sv - scoreboard bench for mc_control_fsm (bne path follows MCCTRL_BNE_EN)
module tb_mc_control_fsm;

   logic       CLK = 1'b0;
   logic       RST;
   logic [5:0] Op;
   logic       ALUZero;
   logic       MemReady;
   logic       PCWrite, IRWrite, MemRead, MemWrite, IorD;
   logic       RegWrite, RegDst, MemtoReg, ALUSrcA, Illegal;
   logic [1:0] PCSrc, ALUSrcB, ALUOp;
   logic [2:0] State;

   int total = 0;
   int bad   = 0;

   logic [18:0] eq[$];
   string       tq[$];

   localparam logic [5:0] R_OP = 6'b000000, LW_OP = 6'b100011, SW_OP = 6'b101011;
   localparam logic [5:0] BEQ_OP = 6'b000100, BNE_OP = 6'b000101, J_OP = 6'b000010;
   localparam logic [5:0] ADDI_OP = 6'b001000, ORI_OP = 6'b001101, LUI_OP = 6'b001111;
   localparam logic [5:0] BAD_OP = 6'b111111;

   mc_control_fsm dut (
      .CLK(CLK), .RST(RST), .Op(Op), .ALUZero(ALUZero), .MemReady(MemReady),
      .PCWrite(PCWrite), .PCSrc(PCSrc), .IRWrite(IRWrite), .MemRead(MemRead),
      .MemWrite(MemWrite), .IorD(IorD), .RegWrite(RegWrite), .RegDst(RegDst),
      .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
      .Illegal(Illegal), .State(State)
   );

   always #5 CLK = ~CLK;

   wire [18:0] outs = {State, PCWrite, PCSrc, IRWrite, MemRead, MemWrite, IorD,
                       RegWrite, RegDst, MemtoReg, ALUSrcA, ALUSrcB, ALUOp, Illegal};

   function automatic logic [18:0] mk(input int st, input int pcw, input int pcs,
                                      input int irw, input int mr, input int mw,
                                      input int iord, input int rw, input int rd,
                                      input int m2r, input int asa, input int asb,
                                      input int aop, input int ill);
      return {3'(st), 1'(pcw), 2'(pcs), 1'(irw), 1'(mr), 1'(mw), 1'(iord),
              1'(rw), 1'(rd), 1'(m2r), 1'(asa), 2'(asb), 2'(aop), 1'(ill)};
   endfunction

   //             st pcw pcs irw mr mw iord rw rd m2r asa asb aop ill
   wire [18:0] E_RST   = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   wire [18:0] E_F_RDY = mk(0, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   wire [18:0] E_F_WT  = mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   wire [18:0] E_DEC   = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0);
   wire [18:0] E_X_R   = mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2, 0);
   wire [18:0] E_X_ADR = mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0);
   wire [18:0] E_X_LOG = mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 3, 0);
   wire [18:0] E_X_BT  = mk(2, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
   wire [18:0] E_X_BN  = mk(2, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
   wire [18:0] E_X_J   = mk(2, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   wire [18:0] E_M_LW  = mk(3, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
   wire [18:0] E_M_SW  = mk(3, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
   wire [18:0] E_W_R   = mk(4, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
   wire [18:0] E_W_LW  = mk(4, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0);
   wire [18:0] E_W_I   = mk(4, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
   wire [18:0] E_ILL   = mk(5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
   wire [18:0] E_X_BNT = mk(2, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
   wire [18:0] E_X_BNN = mk(2, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);

   task automatic chk(input string tag, input logic [18:0] got, input logic [18:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   always @(negedge CLK) begin
      if (eq.size() > 0) chk(tq.pop_front(), outs, eq.pop_front());
   end

   // One cycle of stimulus; the expected outputs for that cycle go to the scoreboard.
   task automatic step(input string tag, input logic [5:0] op, input logic az,
                       input logic mr, input logic [18:0] e);
      Op = op; ALUZero = az; MemReady = mr;
      tq.push_back(tag);
      eq.push_back(e);
      @(posedge CLK);
      #1;
   endtask

   task automatic fd(input string tag, input logic [5:0] op);
      step({tag, "_f"}, op, 1'b0, 1'b1, E_F_RDY);
      step({tag, "_d"}, op, 1'b1, 1'b1, E_DEC);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      RST = 1'b1; Op = '0; ALUZero = 1'b0; MemReady = 1'b0;
      @(posedge CLK); #1;
      step("rst0", R_OP, 1'b0, 1'b1, E_RST);
      step("rst1", R_OP, 1'b1, 1'b1, E_RST);
      RST = 1'b0;

      fd("r", R_OP);
      step("r_x", R_OP, 1'b0, 1'b1, E_X_R);
      step("r_w", R_OP, 1'b0, 1'b1, E_W_R);

      fd("lw", LW_OP);
      step("lw_x", LW_OP, 1'b0, 1'b1, E_X_ADR);
      step("lw_m0", LW_OP, 1'b0, 1'b0, E_M_LW);
      step("lw_m1", LW_OP, 1'b0, 1'b0, E_M_LW);
      step("lw_m2", LW_OP, 1'b0, 1'b1, E_M_LW);
      step("lw_w", LW_OP, 1'b0, 1'b1, E_W_LW);

      step("sw_fw", SW_OP, 1'b0, 1'b0, E_F_WT);
      fd("sw", SW_OP);
      step("sw_x", SW_OP, 1'b0, 1'b1, E_X_ADR);
      step("sw_m", SW_OP, 1'b0, 1'b1, E_M_SW);

      fd("beqt", BEQ_OP);
      step("beqt_x", BEQ_OP, 1'b1, 1'b1, E_X_BT);
      fd("beqn", BEQ_OP);
      step("beqn_x", BEQ_OP, 1'b0, 1'b1, E_X_BN);

      fd("j", J_OP);
      step("j_x", J_OP, 1'b0, 1'b1, E_X_J);

      fd("addi", ADDI_OP);
      step("addi_x", ADDI_OP, 1'b0, 1'b1, E_X_ADR);
      step("addi_w", ADDI_OP, 1'b0, 1'b1, E_W_I);
      fd("ori", ORI_OP);
      step("ori_x", ORI_OP, 1'b0, 1'b1, E_X_LOG);
      step("ori_w", ORI_OP, 1'b0, 1'b1, E_W_I);
      fd("lui", LUI_OP);
      step("lui_x", LUI_OP, 1'b1, 1'b1, E_X_LOG);
      step("lui_w", LUI_OP, 1'b0, 1'b1, E_W_I);

`ifdef MCCTRL_BNE_EN
      fd("bnet", BNE_OP);
      step("bnet_x", BNE_OP, 1'b0, 1'b1, E_X_BNT);
      fd("bnen", BNE_OP);
      step("bnen_x", BNE_OP, 1'b1, 1'b1, E_X_BNN);
`else
      fd("bne", BNE_OP);
      step("bne_ill", BNE_OP, 1'b0, 1'b1, E_ILL);
      RST = 1'b1;
      step("bne_rst", BNE_OP, 1'b0, 1'b1, E_RST);
      RST = 1'b0;
`endif

      // Reset while sw waits in MEM: MemWrite must drop without waiting for an edge.
      fd("swr", SW_OP);
      step("swr_x", SW_OP, 1'b0, 1'b0, E_X_ADR);
      step("swr_m", SW_OP, 1'b0, 1'b0, E_M_SW);
      RST = 1'b1;
      #1;
      chk("swr_async", outs, E_RST);
      step("swr_rst", SW_OP, 1'b0, 1'b1, E_RST);
      RST = 1'b0;
      step("swr_f", R_OP, 1'b0, 1'b1, E_F_RDY);
      step("swr_d", R_OP, 1'b0, 1'b1, E_DEC);
      step("swr_x2", R_OP, 1'b0, 1'b1, E_X_R);
      step("swr_w", R_OP, 1'b0, 1'b1, E_W_R);

      fd("ill", BAD_OP);
      step("ill_0", BAD_OP, 1'b1, 1'b0, E_ILL);
      step("ill_1", BAD_OP, 1'b1, 1'b1, E_ILL);
      step("ill_2", R_OP, 1'b0, 1'b1, E_ILL);
      RST = 1'b1;
      #1;
      chk("ill_async", outs, E_RST);
      step("ill_rst", R_OP, 1'b0, 1'b1, E_RST);
      RST = 1'b0;
      step("ill_f", R_OP, 1'b0, 1'b1, E_F_RDY);
      step("ill_d", R_OP, 1'b0, 1'b1, E_DEC);

      @(negedge CLK);
      chk("sb_empty", 19'(eq.size()), 19'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
